// File: rtl/pll_pkg.sv
// pll_pkg: shared state encoding and default loop constants for the PLL loop filter.
package pll_pkg;

    typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, LOCKED} state_t;

    localparam int CW_DEF         = 10;
    localparam int KP_DEF         = 8;
    localparam int KI_DEF         = 1;
    localparam int ACQ_SHIFT_DEF  = 2;
    localparam int LOCK_COUNT_DEF = 8;
    localparam int UNLOCK_RUN_DEF = 4;

    function automatic int cnt_width(input int n);
        return n < 2 ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pll_lock_detect.sv
// pll_lock_detect: tracks phase-detector alternations and same-direction runs.
// The first sample after a clear only seeds the previous direction.
module pll_lock_detect
    import pll_pkg::*;
#(
    parameter int LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int UNLOCK_RUN = UNLOCK_RUN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic sample,
    input  logic dir,
    output logic toggle,
    output logic lock_hit,
    output logic unlock_hit
);

    localparam int AW = cnt_width(LOCK_COUNT);
    localparam int RW = cnt_width(UNLOCK_RUN);

    logic          seeded;
    logic          prev;
    logic          change;
    logic [AW-1:0] alt;
    logic [AW-1:0] alt_nx;
    logic [RW-1:0] run;
    logic [RW-1:0] run_nx;

    always_comb begin
        change     = seeded && (dir != prev);
        toggle     = sample && change;
        alt_nx     = !change ? '0 : (alt == AW'(LOCK_COUNT)) ? alt : alt + 1'b1;
        run_nx     = !seeded ? '0 : change ? RW'(1) : (run == RW'(UNLOCK_RUN)) ? run : run + 1'b1;
        lock_hit   = sample && (alt_nx == AW'(LOCK_COUNT));
        unlock_hit = sample && (run_nx == RW'(UNLOCK_RUN));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seeded <= 1'b0;
            prev   <= 1'b0;
            alt    <= '0;
            run    <= '0;
        end else if (sample) begin
            seeded <= 1'b1;
            prev   <= dir;
            alt    <= alt_nx;
            run    <= run_nx;
        end else if (clear) begin
            seeded <= 1'b0;
        end
    end

endmodule

// File: rtl/pll_loop_filter.sv
// pll_loop_filter: bang-bang PI loop filter with acquire/track gain switching,
// saturating integrator and lock detection.
module pll_loop_filter
    import pll_pkg::*;
#(
    parameter int CW         = CW_DEF,
    parameter int KP         = KP_DEF,
    parameter int KI         = KI_DEF,
    parameter int ACQ_SHIFT  = ACQ_SHIFT_DEF,
    parameter int LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int UNLOCK_RUN = UNLOCK_RUN_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          dir,
    input  logic          dir_valid,
    output logic [CW-1:0] ctrl_word,
    output logic          ctrl_valid,
    output logic          locked,
    output logic          sat
);

    localparam int W = CW + 2;
    localparam logic [CW-1:0]       MID  = {1'b1, {(CW-1){1'b0}}};
    localparam logic signed [W-1:0] MAXV = {2'b00, {CW{1'b1}}};

    state_t               state;
    logic [CW-1:0]        integ;
    logic [CW-1:0]        integ_nx;
    logic [CW-1:0]        word_nx;
    logic signed [W-1:0]  ki_eff;
    logic signed [W-1:0]  kp_eff;
    logic signed [W-1:0]  i_sum;
    logic signed [W-1:0]  p_sum;
    logic                 upd;
    logic                 toggle;
    logic                 lock_hit;
    logic                 unlock_hit;

    // Sums are held at CW+2 signed bits so both over- and underflow clamp instead of wrapping.
    always_comb begin
        upd      = enable && dir_valid && (state != IDLE);
        ki_eff   = (state == ACQUIRE) ? W'(KI << ACQ_SHIFT) : W'(KI);
        kp_eff   = (state == ACQUIRE) ? W'(KP << ACQ_SHIFT) : W'(KP);
        i_sum    = {2'b00, integ} + (dir ? ki_eff : -ki_eff);
        integ_nx = i_sum[W-1] ? '0 : (i_sum > MAXV) ? '1 : i_sum[CW-1:0];
        p_sum    = {2'b00, integ_nx} + (dir ? kp_eff : -kp_eff);
        word_nx  = p_sum[W-1] ? '0 : (p_sum > MAXV) ? '1 : p_sum[CW-1:0];
    end

    pll_lock_detect #(
        .LOCK_COUNT (LOCK_COUNT),
        .UNLOCK_RUN (UNLOCK_RUN)
    ) u_lock (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == IDLE),
        .sample     (upd),
        .dir        (dir),
        .toggle     (toggle),
        .lock_hit   (lock_hit),
        .unlock_hit (unlock_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            integ      <= MID;
            ctrl_word  <= MID;
            ctrl_valid <= 1'b0;
        end else begin
            ctrl_valid <= upd;
            if (upd) begin
                integ     <= integ_nx;
                ctrl_word <= word_nx;
            end
            if (!enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:    state <= ACQUIRE;
                    ACQUIRE: state <= toggle ? TRACK : ACQUIRE;
                    TRACK:   state <= lock_hit ? LOCKED : TRACK;
                    LOCKED:  state <= unlock_hit ? TRACK : LOCKED;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign locked = (state == LOCKED);
    assign sat    = (integ == '0) || (integ == '1);

endmodule

// File: tb/tb_pll_loop_filter.sv
// tb_pll_loop_filter: randomized and directed checks of pll_loop_filter against
// an integer behavioural model of the loop rules.
module tb_pll_loop_filter;

    localparam int CW   = 10;
    localparam int KP   = 8;
    localparam int KI   = 1;
    localparam int AS   = 2;
    localparam int LC   = 8;
    localparam int UR   = 4;
    localparam int MAXV = (1 << CW) - 1;
    localparam int MIDV = 1 << (CW - 1);

    localparam int S_IDLE = 0, S_ACQ = 1, S_TRACK = 2, S_LOCKED = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          dir = 1'b0;
    logic          dir_valid = 1'b0;
    logic [CW-1:0] ctrl_word;
    logic          ctrl_valid;
    logic          locked;
    logic          sat;

    int n_chk  = 0;
    int n_pass = 0;

    int m_st, m_integ, m_word, m_alt, m_run;
    bit m_valid, m_prev, m_seeded;

    pll_loop_filter #(
        .CW(CW), .KP(KP), .KI(KI), .ACQ_SHIFT(AS), .LOCK_COUNT(LC), .UNLOCK_RUN(UR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .dir        (dir),
        .dir_valid  (dir_valid),
        .ctrl_word  (ctrl_word),
        .ctrl_valid (ctrl_valid),
        .locked     (locked),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int clamp(input int v);
        return v < 0 ? 0 : (v > MAXV ? MAXV : v);
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_integ = MIDV; m_word = MIDV; m_valid = 0;
        m_alt = 0; m_run = 0; m_prev = 0; m_seeded = 0;
    endtask

    task automatic model_step(input bit en, input bit v, input bit d);
        bit upd, chg;
        int ki, kp, ns;
        upd = en && v && m_st != S_IDLE;
        chg = 0;
        m_valid = upd;
        if (upd) begin
            ki = (m_st == S_ACQ) ? (KI << AS) : KI;
            kp = (m_st == S_ACQ) ? (KP << AS) : KP;
            m_integ = clamp(m_integ + (d ? ki : -ki));
            m_word  = clamp(m_integ + (d ? kp : -kp));
            if (!m_seeded) begin
                m_seeded = 1; m_alt = 0; m_run = 0;
            end else if (d != m_prev) begin
                chg = 1; m_alt = (m_alt < LC) ? m_alt + 1 : LC; m_run = 1;
            end else begin
                m_alt = 0; m_run = (m_run < UR) ? m_run + 1 : UR;
            end
            m_prev = d;
        end
        if (m_st == S_IDLE) m_seeded = 0;
        ns = m_st;
        if (!en) ns = S_IDLE;
        else if (m_st == S_IDLE) ns = S_ACQ;
        else if (m_st == S_ACQ && chg) ns = S_TRACK;
        else if (m_st == S_TRACK && upd && m_alt == LC) ns = S_LOCKED;
        else if (m_st == S_LOCKED && upd && m_run == UR) ns = S_TRACK;
        m_st = ns;
    endtask

    task automatic step(input bit en, input bit v, input bit d);
        enable = en; dir_valid = v; dir = d;
        @(posedge clk);
        model_step(en, v, d);
        #1;
        chk("word", int'(ctrl_word), m_word);
        chk("valid", int'(ctrl_valid), int'(m_valid));
        chk("locked", int'(locked), int'(m_st == S_LOCKED));
        chk("sat", int'(sat), int'(m_integ == 0 || m_integ == MAXV));
    endtask

    task automatic rst_pulse();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_word", int'(ctrl_word), MIDV);
        chk("rst_locked", int'(locked), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_valid", int'(ctrl_valid), 0);
        #1 rst = 1'b0;
    endtask

    initial begin
        int held, held_integ;
        bit d;
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_word", int'(ctrl_word), 512);
        chk("rst_locked", int'(locked), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_valid", int'(ctrl_valid), 0);
        #1 rst = 1'b0;

        // acquire gain
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 1, 1);
        chk("acq_integ", int'(dut.integ), 516);
        chk("acq_word", int'(ctrl_word), 548);
        chk("acq_valid", int'(ctrl_valid), 1);
        step(1, 0, 0);
        chk("acq_pulse_end", int'(ctrl_valid), 0);

        // saturation and release
        for (int i = 0; i < 140; i++) step(1, 1, 1);
        chk("sat_word", int'(ctrl_word), 1023);
        chk("sat_flag", int'(sat), 1);
        step(1, 1, 0);
        chk("unsat_flag", int'(sat), 0);
        chk("unsat_word", int'(ctrl_word), 987);

        // freeze and resume in acquire
        held = m_word;
        held_integ = m_integ;
        for (int i = 0; i < 3; i++) step(0, 1, i[0]);
        chk("frz_word", int'(ctrl_word), held);
        chk("frz_valid", int'(ctrl_valid), 0);
        step(1, 1, 1);
        chk("frz_idle_valid", int'(ctrl_valid), 0);
        step(1, 1, 0);
        chk("resume_word", int'(ctrl_word), clamp(held_integ - 4 - 32));

        // lock at ctrl_word 600, then reset mid-operation
        rst_pulse();
        step(1, 0, 0);
        for (int i = 0; i < 25; i++) step(1, 1, 1);
        step(1, 1, 0);
        for (int i = 0; i < 7; i++) step(1, 1, ~i[0]);
        chk("lock600_locked", int'(locked), 1);
        step(1, 1, 0);
        chk("lock600_word", int'(ctrl_word), 600);
        chk("lock600_hold", int'(locked), 1);
        rst_pulse();
        step(1, 1, 1);
        chk("post_rst_valid", int'(ctrl_valid), 0);
        chk("post_rst_word", int'(ctrl_word), 512);

        // lock after 8 alternations, unlock after a run of 4
        step(1, 1, 1);
        for (int i = 0; i < 7; i++) step(1, 1, i[0]);
        chk("lock_early", int'(locked), 0);
        step(1, 1, 1);
        chk("lock_rise", int'(locked), 1);
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        chk("lock_hold", int'(locked), 1);
        step(1, 1, 0);
        chk("lock_fall", int'(locked), 0);

        // randomized traffic, biased toward alternation so lock is reachable
        d = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) != 0) d = ~d;
            step($urandom_range(0, 19) != 0, $urandom_range(0, 2) != 0, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
